// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver for the 32f link: aligns on the comma,
// locks after LOCK_COUNT aligned commas, then emits each byte.
// Ports: clk_32f, reset (sync, active-low), data_in (serial, MSB first)
//        data_out[7:0], valid_out, byte_strobe, active.
module serial_paralelo #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    LOCKED
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] sr;
  logic [7:0] word;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_n;
  logic [3:0] comma_cnt;
  logic [3:0] comma_cnt_n;
  logic [7:0] data_n;
  logic       valid_n;
  logic       strobe_n;
  logic       is_comma;
  logic       boundary;

  assign word     = {sr[6:0], data_in};
  assign is_comma = (word == COMMA);
  assign boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt + 3'd1;
    comma_cnt_n = comma_cnt;
    data_n      = data_out;
    valid_n     = valid_out;
    strobe_n    = 1'b0;
    unique case (state)
      SEARCH: begin
        // Hunt at every bit offset; a match fixes the byte phase.
        bit_cnt_n = 3'd0;
        if (is_comma) begin
          comma_cnt_n = 4'd1;
          state_n     = (LOCK_N == 4'd1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_n = comma_cnt + 4'd1;
            if (comma_cnt + 4'd1 == LOCK_N)
              state_n = LOCKED;
          end else begin
            comma_cnt_n = 4'd0;
            state_n     = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          strobe_n = 1'b1;
          if (is_comma) begin
            valid_n = 1'b0;
          end else begin
            data_n  = word;
            valid_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state       <= SEARCH;
      sr          <= '0;
      bit_cnt     <= '0;
      comma_cnt   <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= word;
      bit_cnt     <= bit_cnt_n;
      comma_cnt   <= comma_cnt_n;
      data_out    <= data_n;
      valid_out   <= valid_n;
      byte_strobe <= strobe_n;
      active      <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Testbench for serial_paralelo: directed scenarios plus randomized
// streams checked against a byte-level model of the link.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int checks = 0;
  int errors = 0;

  // byte-level model state
  int         m_cnt;
  logic       m_lock;
  logic [7:0] m_data;
  logic       m_valid;

  localparam logic [7:0] BC = 8'hBC;

  serial_paralelo dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic strobe_e);
    chk({tag, ".active"}, {7'd0, active}, {7'd0, m_lock});
    chk({tag, ".strobe"}, {7'd0, byte_strobe}, {7'd0, strobe_e});
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, m_valid});
    chk({tag, ".data"}, data_out, m_data);
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_32f);
      #1;
    end
    m_cnt   = 0;
    m_lock  = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    chk_outs("reset", 1'b0);
    reset = 1'b1;
  endtask

  // raw bits outside any byte frame: nothing may change
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = b[i];
      @(posedge clk_32f);
      #1;
      chk_outs("bits", 1'b0);
    end
  endtask

  // one aligned byte, MSB first; model updates on the LSB edge
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      logic s;
      data_in = b[i];
      @(posedge clk_32f);
      #1;
      s = 1'b0;
      if (i == 0) begin
        if (m_lock) begin
          s = 1'b1;
          if (b == BC) m_valid = 1'b0;
          else begin
            m_data  = b;
            m_valid = 1'b1;
          end
        end else begin
          m_cnt = (b == BC) ? m_cnt + 1 : 0;
          if (m_cnt == 4) m_lock = 1'b1;
        end
      end
      chk_outs($sformatf("byte_%h_b%0d", b, i), s);
    end
  endtask

  // position of the first comma in a bit stream starting from all zeros
  function automatic int first_comma(input logic q[$]);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < q.size(); i++) begin
      w = {w[6:0], q[i]};
      if (w == BC) return i;
    end
    return -1;
  endfunction

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;

    // 1: lock on four commas
    do_reset(3);
    for (int k = 0; k < 4; k++) send_byte(BC);
    chk("lock1.active", {7'd0, active}, 8'd1);

    // 2: data bytes
    send_byte(8'hA5);
    send_byte(8'h3C);

    // 3: comma after data keeps data, clears valid
    send_byte(8'hA5);
    send_byte(BC);

    // 4: alignment at bit offset 3
    do_reset(2);
    send_bits(8'b101, 3);
    for (int k = 0; k < 4; k++) send_byte(BC);
    send_byte(8'h5A);

    // 5: broken comma run returns to search
    do_reset(2);
    send_byte(BC);
    send_byte(BC);
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(BC);
    send_byte(8'h77);

    // 6: reset mid-byte while locked
    do_reset(1);
    for (int k = 0; k < 4; k++) send_byte(BC);
    send_byte(8'hC3);
    send_bits(8'b110, 3);
    do_reset(1);
    for (int k = 0; k < 4; k++) send_byte(BC);
    send_byte(8'h81);

    // randomized streams
    for (int r = 0; r < 12; r++) begin
      logic [7:0] junk;
      int         len;
      logic       q[$];
      len  = 0;
      junk = 8'h00;
      for (int t = 0; t < 20; t++) begin
        len  = $urandom_range(0, 7);
        junk = 8'($urandom);
        q.delete();
        for (int i = len - 1; i >= 0; i--) q.push_back(junk[i]);
        for (int i = 7; i >= 0; i--) q.push_back(BC[i]);
        if (first_comma(q) == len + 7) break;
        junk = 8'h00;
      end
      do_reset(2);
      if (len > 0) send_bits(junk, len);
      for (int k = 0; k < 4; k++) send_byte(BC);
      for (int k = 0; k < 6; k++) begin
        logic [7:0] b;
        b = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom);
        send_byte(b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
